// File: rtl/lsu_bus_arbiter.sv
// lsu_bus_arbiter
//
// Shares the single LSU load/store port between the core data path and a
// debug/host loader. One access is in flight at a time:
//   IDLE -> ACCESS -> (WAIT)* -> RESP -> IDLE
// Each access gets a one-cycle LSU strobe, a fixed read latency of RD_LAT
// cycles for loads, and a one-cycle ack to the requester that won.
//
// Parameters:
//   RD_LAT  LSU read latency in cycles, address valid to i_lsu_rdata valid (0..7)
//   ADDR_W  address width
//
// Ports:
//   i_clk, i_reset          clock (rising edge), asynchronous active-low reset
//   i_core_*                core request: req/wren/addr/wdata/mask, req held until ack
//   o_core_ack/rdata/stall  core completion pulse, registered load data, hold request
//   i_host_*                host request, same rules as the core
//   o_host_ack/rdata        host completion pulse, registered load data
//   o_lsu_*                 LSU address/store data/write strobe/byte mask
//   i_lsu_rdata             LSU load data
//   o_busy                  FSM is not idle
//
// Build option:
//   LSU_ARB_HOST_PRIO_EN  when defined, the host wins every tie (fixed priority)
//                         and the core can be starved while the host streams.
//                         When undefined, ties alternate (round-robin).

module lsu_bus_arbiter #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,

    input  logic              i_core_req,
    input  logic              i_core_wren,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic [31:0]       i_core_wdata,
    input  logic [3:0]        i_core_mask,
    output logic              o_core_ack,
    output logic [31:0]       o_core_rdata,
    output logic              o_core_stall,

    input  logic              i_host_req,
    input  logic              i_host_wren,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [31:0]       i_host_wdata,
    input  logic [3:0]        i_host_mask,
    output logic              o_host_ack,
    output logic [31:0]       o_host_rdata,

    output logic [ADDR_W-1:0] o_lsu_addr,
    output logic [31:0]       o_lsu_wdata,
    output logic              o_lsu_wren,
    output logic [3:0]        o_lsu_mask,
    input  logic [31:0]       i_lsu_rdata,

    output logic              o_busy
);

    localparam logic [2:0] RdLat   = 3'(RD_LAT);
    localparam bit         ZeroLat = (RD_LAT == 0);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic                grant_host_q, grant_host_d;  // owner of the access in flight
    logic                last_host_q, last_host_d;    // last winner, resets to host
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          mask_q, mask_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [31:0]         core_rdata_q, core_rdata_d;
    logic [31:0]         host_rdata_q, host_rdata_d;

    logic                pick_host;
    logic                capture;

    // Winner selection, only meaningful while at least one request is high.
`ifdef LSU_ARB_HOST_PRIO_EN
    assign pick_host = i_host_req;
`else
    // On a tie the requester that did not win last time goes next.
    assign pick_host = i_host_req & (~i_core_req | ~last_host_q);
`endif

    always_comb begin
        state_d      = state_q;
        grant_host_d = grant_host_q;
        last_host_d  = last_host_q;
        wren_d       = wren_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        cnt_d        = cnt_q;
        capture      = 1'b0;

        o_lsu_addr   = '0;
        o_lsu_wdata  = '0;
        o_lsu_wren   = 1'b0;
        o_lsu_mask   = '0;
        o_core_ack   = 1'b0;
        o_host_ack   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_core_req || i_host_req) begin
                    grant_host_d = pick_host;
                    last_host_d  = pick_host;
                    wren_d       = pick_host ? i_host_wren  : i_core_wren;
                    addr_d       = pick_host ? i_host_addr  : i_core_addr;
                    wdata_d      = pick_host ? i_host_wdata : i_core_wdata;
                    mask_d       = pick_host ? i_host_mask  : i_core_mask;
                    state_d      = StAccess;
                end
            end

            StAccess: begin
                o_lsu_addr  = addr_q;
                o_lsu_wdata = wdata_q;
                o_lsu_wren  = wren_q;
                o_lsu_mask  = mask_q;
                if (wren_q) begin
                    state_d = StResp;
                end else if (ZeroLat) begin
                    capture = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d   = 3'd1;
                    state_d = StWait;
                end
            end

            StWait: begin
                o_lsu_addr = addr_q;
                o_lsu_mask = mask_q;
                if (cnt_q == RdLat) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            StResp: begin
                o_core_ack = ~grant_host_q;
                o_host_ack = grant_host_q;
                state_d    = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Load data goes only to the owner's register; everything else holds.
    always_comb begin
        core_rdata_d = core_rdata_q;
        host_rdata_d = host_rdata_q;
        if (capture) begin
            if (grant_host_q) begin
                host_rdata_d = i_lsu_rdata;
            end else begin
                core_rdata_d = i_lsu_rdata;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= StIdle;
            grant_host_q <= 1'b0;
            last_host_q  <= 1'b1;
            wren_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            cnt_q        <= '0;
            core_rdata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_host_q <= grant_host_d;
            last_host_q  <= last_host_d;
            wren_q       <= wren_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
            core_rdata_q <= core_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign o_core_rdata = core_rdata_q;
    assign o_host_rdata = host_rdata_q;
    assign o_busy       = (state_q != StIdle);

    // Gated by reset so every output reads 0 while reset is held, even if
    // the core keeps its request up.
    assign o_core_stall = i_core_req & ~o_core_ack & i_reset;

endmodule

// File: tb/tb_lsu_bus_arbiter.sv
// Scoreboard bench for lsu_bus_arbiter: stimulus pushes the expected ack
// (who, cycle, both rdata registers); a monitor pops on every ack.
// A small LSU model returns load data only in the cycle RD_LAT after ACCESS.

module tb_lsu_bus_arbiter;

    localparam int unsigned RD_LAT = 1;
    localparam int unsigned ADDR_W = 32;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_core_req, i_core_wren;
    logic [ADDR_W-1:0] i_core_addr;
    logic [31:0]       i_core_wdata;
    logic [3:0]        i_core_mask;
    logic              o_core_ack, o_core_stall;
    logic [31:0]       o_core_rdata;
    logic              i_host_req, i_host_wren;
    logic [ADDR_W-1:0] i_host_addr;
    logic [31:0]       i_host_wdata;
    logic [3:0]        i_host_mask;
    logic              o_host_ack;
    logic [31:0]       o_host_rdata;
    logic [ADDR_W-1:0] o_lsu_addr;
    logic [31:0]       o_lsu_wdata;
    logic              o_lsu_wren;
    logic [3:0]        o_lsu_mask;
    logic [31:0]       i_lsu_rdata;
    logic              o_busy;

    lsu_bus_arbiter #(
        .RD_LAT (RD_LAT),
        .ADDR_W (ADDR_W)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_core_req   (i_core_req),
        .i_core_wren  (i_core_wren),
        .i_core_addr  (i_core_addr),
        .i_core_wdata (i_core_wdata),
        .i_core_mask  (i_core_mask),
        .o_core_ack   (o_core_ack),
        .o_core_rdata (o_core_rdata),
        .o_core_stall (o_core_stall),
        .i_host_req   (i_host_req),
        .i_host_wren  (i_host_wren),
        .i_host_addr  (i_host_addr),
        .i_host_wdata (i_host_wdata),
        .i_host_mask  (i_host_mask),
        .o_host_ack   (o_host_ack),
        .o_host_rdata (o_host_rdata),
        .o_lsu_addr   (o_lsu_addr),
        .o_lsu_wdata  (o_lsu_wdata),
        .o_lsu_wren   (o_lsu_wren),
        .o_lsu_mask   (o_lsu_mask),
        .i_lsu_rdata  (i_lsu_rdata),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- LSU model ----------------
    function automatic logic [31:0] mem(input logic [ADDR_W-1:0] a);
        case (a)
            32'h0000_1000: mem = 32'h1234_5678;
            32'h0000_3000: mem = 32'h5555_AAAA;
            32'h0000_7010: mem = 32'hCAFE_F00D;
            default:       mem = 32'hDEAD_0000;
        endcase
    endfunction

    logic [ADDR_W-1:0] prev_addr = '0;
    int                k_q = 0;
    int                k_now;
    logic              acc_start;

    // Every access is preceded by a cycle with the address bus at zero.
    always @(posedge i_clk) begin
        prev_addr <= o_lsu_addr;
        k_q       <= acc_start ? 1 : k_q + 1;
    end

    always_comb begin
        acc_start   = (o_lsu_addr != '0) && (prev_addr == '0);
        k_now       = acc_start ? 0 : k_q;
        i_lsu_rdata = 32'hFFFF_FFFF;
        if (o_lsu_addr != '0 && k_now == int'(RD_LAT)) i_lsu_rdata = mem(o_lsu_addr);
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        string       tag;
        bit          host;
        int          cyc;
        logic [31:0] core_rd;
        logic [31:0] host_rd;
    } exp_t;

    exp_t sb[$];

    task automatic push(input string tag, input bit host, input int c,
                        input logic [31:0] crd, input logic [31:0] hrd);
        exp_t e;
        e.tag = tag; e.host = host; e.cyc = c; e.core_rd = crd; e.host_rd = hrd;
        sb.push_back(e);
    endtask

    always @(negedge i_clk) begin
        if (i_reset === 1'b1 && (o_core_ack || o_host_ack)) begin
            chk("dual_ack", 64'(o_core_ack & o_host_ack), 64'd0);
            if (sb.size() == 0) begin
                chk("ack_expected", 64'(sb.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, "_who"},   64'(o_host_ack),   64'(e.host));
                chk({e.tag, "_cycle"}, 64'(cyc),          64'(e.cyc));
                chk({e.tag, "_core_rdata"}, 64'(o_core_rdata), 64'(e.core_rd));
                chk({e.tag, "_host_rdata"}, 64'(o_host_rdata), 64'(e.host_rd));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic start(input bit host, input bit wren, input logic [ADDR_W-1:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask);
        if (host) begin
            i_host_req = 1'b1; i_host_wren = wren; i_host_addr = addr;
            i_host_wdata = wdata; i_host_mask = mask;
        end else begin
            i_core_req = 1'b1; i_core_wren = wren; i_core_addr = addr;
            i_core_wdata = wdata; i_core_mask = mask;
        end
    endtask

    // Wait (bounded) for this requester's ack, then drop req for the next cycle.
    task automatic finish(input bit host);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (host ? o_host_ack : o_core_ack) got = 1'b1;
            else @(negedge i_clk);
        end
        chk(host ? "host_ack_seen" : "core_ack_seen", 64'(got), 64'd1);
        @(posedge i_clk);
        #1;
        if (host) i_host_req = 1'b0;
        else      i_core_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    int c0;

    initial begin
        i_reset = 1'b0;
        i_core_req = 0; i_core_wren = 0; i_core_addr = '0; i_core_wdata = '0; i_core_mask = '0;
        i_host_req = 0; i_host_wren = 0; i_host_addr = '0; i_host_wdata = '0; i_host_mask = '0;

        // Reset state
        idle(2);
        @(negedge i_clk);
        chk("rst_ctl", 64'({o_core_ack, o_host_ack, o_core_stall, o_busy, o_lsu_wren, o_lsu_mask}),
            64'd0);
        chk("rst_lsu_addr", 64'(o_lsu_addr), 64'd0);
        chk("rst_lsu_wdata", 64'(o_lsu_wdata), 64'd0);
        chk("rst_core_rdata", 64'(o_core_rdata), 64'd0);
        chk("rst_host_rdata", 64'(o_host_rdata), 64'd0);
        @(posedge i_clk);
        #1 i_reset = 1'b1;
        idle(1);

        // Core store alone
        c0 = cyc;
        start(1'b0, 1'b1, 32'h0000_7020, 32'hDEAD_BEEF, 4'hF);
        push("st_core", 1'b0, c0 + 2, 32'h0, 32'h0);
        @(negedge i_clk);
        chk("st_c0_stall", 64'(o_core_stall), 64'd1);
        chk("st_c0_wren_busy", 64'({o_lsu_wren, o_busy}), 64'd0);
        @(negedge i_clk);
        chk("st_c1_wren", 64'(o_lsu_wren), 64'd1);
        chk("st_c1_addr", 64'(o_lsu_addr), 64'h7020);
        chk("st_c1_wdata", 64'(o_lsu_wdata), 64'hDEAD_BEEF);
        chk("st_c1_mask", 64'(o_lsu_mask), 64'hF);
        chk("st_c1_stall_busy", 64'({o_core_stall, o_busy}), 64'b11);
        @(negedge i_clk);
        chk("st_c2_wren", 64'(o_lsu_wren), 64'd0);
        chk("st_c2_stall", 64'(o_core_stall), 64'd0);
        chk("st_c2_addr", 64'(o_lsu_addr), 64'd0);
        finish(1'b0);
        @(negedge i_clk);
        chk("st_c3_busy", 64'(o_busy), 64'd0);
        idle(1);

        // Core load, data present only RD_LAT cycles after ACCESS
        c0 = cyc;
        start(1'b0, 1'b0, 32'h0000_1000, 32'h0, 4'h3);
        push("ld_core", 1'b0, c0 + 2 + int'(RD_LAT), 32'h1234_5678, 32'h0);
        repeat (2) @(negedge i_clk);
        chk("ld_access_addr", 64'(o_lsu_addr), 64'h1000);
        chk("ld_access_wren", 64'(o_lsu_wren), 64'd0);
        finish(1'b0);
        idle(1);

        // Tie after a core grant: host goes first, core waits stalled
        c0 = cyc;
        start(1'b1, 1'b0, 32'h0000_7010, 32'h0, 4'hF);
        start(1'b0, 1'b1, 32'h0000_7024, 32'h0102_0304, 4'hC);
        push("ld_host_tie", 1'b1, c0 + 2 + int'(RD_LAT), 32'h1234_5678, 32'hCAFE_F00D);
        push("st_core_after", 1'b0, c0 + 5 + int'(RD_LAT), 32'h1234_5678, 32'hCAFE_F00D);
        repeat (2) @(negedge i_clk);
        chk("tie_winner_addr", 64'(o_lsu_addr), 64'h7010);
        chk("tie_core_stall", 64'(o_core_stall), 64'd1);
        finish(1'b1);
        @(negedge i_clk);
        chk("gap_busy", 64'(o_busy), 64'd0);
        chk("gap_stall", 64'(o_core_stall), 64'd1);
        @(negedge i_clk);
        chk("st2_busy", 64'(o_busy), 64'd1);
        chk("st2_wren", 64'(o_lsu_wren), 64'd1);
        chk("st2_addr", 64'(o_lsu_addr), 64'h7024);
        chk("st2_wdata", 64'(o_lsu_wdata), 64'h0102_0304);
        chk("st2_mask", 64'(o_lsu_mask), 64'hC);
        finish(1'b0);
        idle(1);

        // Reset in the middle of a core load: no ack, everything cleared
        start(1'b0, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
        repeat ((RD_LAT > 0) ? 2 : 1) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        i_core_req = 1'b0;
        @(negedge i_clk);
        chk("mid_rst_ctl",
            64'({o_core_ack, o_host_ack, o_core_stall, o_busy, o_lsu_wren, o_lsu_mask}), 64'd0);
        chk("mid_rst_addr", 64'(o_lsu_addr), 64'd0);
        chk("mid_rst_core_rdata", 64'(o_core_rdata), 64'd0);
        chk("mid_rst_host_rdata", 64'(o_host_rdata), 64'd0);
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b1;
        idle(2);

        // Both requesting after reset: core, host, core, host
        c0 = cyc;
        push("rr_core0", 1'b0, c0 + 2, 32'h0, 32'h0);
        push("rr_host0", 1'b1, c0 + 5 + int'(RD_LAT), 32'h0, 32'h5555_AAAA);
        push("rr_core1", 1'b0, c0 + 8 + int'(RD_LAT), 32'h0, 32'h5555_AAAA);
        push("rr_host1", 1'b1, c0 + 11 + 2 * int'(RD_LAT), 32'h0, 32'hCAFE_F00D);
        fork
            begin
                start(1'b0, 1'b1, 32'h0000_2000, 32'h1111_1111, 4'hF);
                finish(1'b0);
                idle(1);
                start(1'b0, 1'b1, 32'h0000_2004, 32'h2222_2222, 4'hF);
                finish(1'b0);
            end
            begin
                start(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'hF);
                finish(1'b1);
                idle(1);
                start(1'b1, 1'b0, 32'h0000_7010, 32'h0, 4'hF);
                finish(1'b1);
            end
        join

        repeat (4) @(negedge i_clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("end_busy", 64'(o_busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_bus_arbiter.md
Name: lsu_bus_arbiter

Overview:
- Shares the single LSU load/store port between two requesters: the core data path (core) and a debug/host loader (host).
- Serializes accesses through a small FSM and waits a fixed LSU read latency.
- Returns read data and a one-cycle ack to the winning requester.
- Drives o_core_stall so the PC register and register-file write hold while a core access is outstanding.

Parameters:
RD_LAT, 1, LSU read latency in cycles from address valid to i_lsu_rdata valid (legal 0..7)
ADDR_W, 32, address width

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset  in  1  asynchronous, active-low reset
i_core_req  in  1  core access request, held until ack
i_core_wren  in  1  1=store, 0=load
i_core_addr  in  ADDR_W  byte address
i_core_wdata  in  32  store data
i_core_mask  in  4  byte mask, passed through unmodified
o_core_ack  out  1  one-cycle completion pulse
o_core_rdata  out  32  registered load data
o_core_stall  out  1  core must hold PC/state
i_host_req, i_host_wren, i_host_addr, i_host_wdata, i_host_mask  in  1/1/ADDR_W/32/4  host request, same rules as core
o_host_ack  out  1  one-cycle completion pulse
o_host_rdata  out  32  registered load data
o_lsu_addr  out  ADDR_W  LSU address
o_lsu_wdata  out  32  LSU store data
o_lsu_wren  out  1  LSU write strobe
o_lsu_mask  out  4  LSU byte mask
i_lsu_rdata  in  32  LSU load data
o_busy  out  1  FSM not in IDLE

Behaviour:
- Reset (i_reset=0, asynchronous):
  - State=IDLE, last_grant=HOST, wait counter=0.
  - All outputs 0, including both rdata registers.
  - An in-flight access is abandoned: no ack, no further wren. The requester re-issues it after reset.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If any req is high, select a winner and latch its wren/addr/wdata/mask, then go to ACCESS.
  - If only one req is high, that requester wins.
  - If both are high, round-robin: the requester other than last_grant wins.
  - last_grant is updated to the winner on entry to ACCESS.
- ACCESS (exactly 1 cycle):
  - o_lsu_addr/mask/wdata = latched values.
  - o_lsu_wren = latched wren, so a store strobe is exactly one cycle.
  - Store: go to RESP.
  - Load with RD_LAT=0: capture i_lsu_rdata this cycle, then go to RESP.
  - Load with RD_LAT>0: go to WAIT with counter=1.
- WAIT:
  - o_lsu_addr/mask stay at latched values; wren=0.
  - When counter==RD_LAT, capture i_lsu_rdata into the winner's rdata register and go to RESP.
  - Otherwise increment the counter.
- RESP (1 cycle):
  - Pulse the winner's ack; go to IDLE.
  - o_lsu_* = 0.
- IDLE drives o_lsu_* = 0.
- Latency from req sampled in IDLE to ack:
  - Store: 2 cycles.
  - Load: RD_LAT+2 cycles.
- After an ack the requester must drop req in the next cycle. Back-to-back accesses from the same requester therefore see one IDLE cycle between them.
- rdata registers:
  - Change only on a load capture for that requester.
  - Stores and the other requester's accesses leave them unchanged.
- o_core_stall = i_core_req & ~o_core_ack (combinational). It also covers cycles where the host holds the port.
- Req dropped before ack is illegal. The FSM still completes the access and pulses ack.
- A new req arriving in RESP is not sampled until IDLE.
- The mask is never checked for alignment.

Optional Feature:
- Macro LSU_ARB_HOST_PRIO_EN.
- Defined: host wins every tie (fixed priority), last_grant is unused, and the core can be starved while the host streams.
- Undefined: round-robin as above. With both requesters continuously requesting, grants strictly alternate.

Test Plan:
- Reset mid-operation: core load to 0x0000_1000, assert i_reset=0 during WAIT -> no o_core_ack; all outputs 0 next edge; o_core_rdata=0.
- Core store alone: addr 0x0000_7020, wdata 0xDEAD_BEEF, mask 4'hF -> o_lsu_wren high exactly 1 cycle (cycle 1); o_core_ack at cycle 2; o_core_stall high cycles 0-1.
- Core load with RD_LAT=1: i_lsu_rdata=0x1234_5678 in WAIT -> o_core_ack at cycle 3; o_core_rdata=0x1234_5678; o_host_rdata unchanged.
- Both requesters held continuously after reset (round-robin build) -> grants core, host, core, host; with LSU_ARB_HOST_PRIO_EN -> host every time, o_core_stall stays high.
- Host load 0x0000_7010 then core store -> o_host_rdata holds the load value after the core store; o_busy low exactly 1 cycle between accesses.
- RD_LAT=0 build, core load -> o_core_ack 2 cycles after req; data captured during ACCESS.
